// File: rtl/swd_spi_bridge_v2.sv
// SPI-clocked SWD front end: one rst_n-high SPI burst carries one SWD packet.
// SCK is forwarded as SWCLK; MOSI/MISO are steered onto/off SWDIO according to packet phase.
module swd_spi_bridge_v2 #(
    parameter int PAD_BITS   = 3,
    parameter int TRN_CYCLES = 1,
    parameter int WR_TRN     = 0,
    parameter int DATA_W     = 32,
    parameter int WR_PAR_GEN = 0
) (
    input  logic              sck,
    input  logic              rst_n,
    input  logic              mosi,
    output logic              miso,
    output logic              swclk,
    inout  wire               swdio,
    output logic              swdio_oe,
    output logic [2:0]        ack,
    output logic              ack_ok,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              parity_err,
    output logic              req_err,
    output logic              frame_done
);

    typedef enum logic [3:0] {
        ST_PAD, ST_REQ, ST_TRN1, ST_ACK, ST_WTRN, ST_WDATA, ST_WPAR,
        ST_RDATA, ST_RPAR, ST_RTRN, ST_ATRN, ST_DONE
    } state_e;

    // Phase boundaries expressed as absolute bit positions within the frame.
    localparam int END_PAD   = PAD_BITS;
    localparam int END_REQ   = END_PAD + 8;
    localparam int END_TRN1  = END_REQ + TRN_CYCLES;
    localparam int END_ACK   = END_TRN1 + 3;
    localparam int END_WTRN  = END_ACK + WR_TRN;
    localparam int END_WDATA = END_WTRN + DATA_W;
    localparam int END_WPAR  = END_WDATA + 1;
    localparam int END_RDATA = END_ACK + DATA_W;
    localparam int END_RPAR  = END_RDATA + 1;
    localparam int END_RTRN  = END_RPAR + TRN_CYCLES;
    localparam int END_ATRN  = END_ACK + TRN_CYCLES;
    localparam int MAX_LEN   = (END_WPAR > END_RTRN) ? END_WPAR : END_RTRN;
    localparam int CNT_W     = $clog2(MAX_LEN + 1);

    localparam state_e RESET_ST = (PAD_BITS == 0) ? ST_REQ : ST_PAD;

    function automatic logic host_drives(input state_e st);
        return (st == ST_REQ) || (st == ST_WDATA) || (st == ST_WPAR);
    endfunction

    function automatic logic clk_enabled(input state_e st);
        return (st != ST_PAD) && (st != ST_DONE);
    endfunction

    // Request byte framing: start=1, stop=0, park=1, even parity over APnDP/RnW/A[3:2].
    function automatic logic req_bad(input logic [7:0] r);
        return (r[0] != 1'b1) || (r[6] != 1'b0) || (r[7] != 1'b1) || (r[5] != (^r[4:1]));
    endfunction

    function automatic logic odd_par_err(input logic [DATA_W-1:0] d, input logic p);
        return (^{d, p}) != 1'b1;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [6:0]         req_q;
    logic               rnw_q;
    logic               req_err_q;
    logic [2:0]         ack_q;
    logic               ack_ok_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               rdata_valid_q;
    logic               parity_err_q;
    logic               wpar_q;
    logic               frame_done_q;
    logic               oe_q;
    logic               clk_en_q;

    logic               last_s;
    logic [7:0]         req_full_s;
    logic [2:0]         ack_full_s;
    logic               ack_ok_s;
    logic               drv_s;
    logic               mirror_s;

    assign req_full_s = {mosi, req_q};
    assign ack_full_s = {swdio, ack_q[2:1]};
    assign ack_ok_s   = (ack_full_s == 3'b001);

    // Detects the last bit of the current phase from the absolute bit counter.
    always_comb begin
        last_s = 1'b0;
        case (state_q)
            ST_PAD:   last_s = (cnt_q == CNT_W'(END_PAD - 1));
            ST_REQ:   last_s = (cnt_q == CNT_W'(END_REQ - 1));
            ST_TRN1:  last_s = (cnt_q == CNT_W'(END_TRN1 - 1));
            ST_ACK:   last_s = (cnt_q == CNT_W'(END_ACK - 1));
            ST_WTRN:  last_s = (cnt_q == CNT_W'(END_WTRN - 1));
            ST_WDATA: last_s = (cnt_q == CNT_W'(END_WDATA - 1));
            ST_WPAR:  last_s = (cnt_q == CNT_W'(END_WPAR - 1));
            ST_RDATA: last_s = (cnt_q == CNT_W'(END_RDATA - 1));
            ST_RPAR:  last_s = (cnt_q == CNT_W'(END_RPAR - 1));
            ST_RTRN:  last_s = (cnt_q == CNT_W'(END_RTRN - 1));
            ST_ATRN:  last_s = (cnt_q == CNT_W'(END_ATRN - 1));
            default:  last_s = 1'b0;
        endcase
    end

    // Next-state selection; the ACK branch uses the third ACK bit as it is sampled.
    always_comb begin
        state_d = state_q;
        if (last_s) begin
            case (state_q)
                ST_PAD:   state_d = ST_REQ;
                ST_REQ:   state_d = ST_TRN1;
                ST_TRN1:  state_d = ST_ACK;
                ST_ACK: begin
                    if (!ack_ok_s) begin
                        state_d = ST_ATRN;
                    end else if (rnw_q) begin
                        state_d = ST_RDATA;
                    end else if (WR_TRN > 0) begin
                        state_d = ST_WTRN;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
                ST_WTRN:  state_d = ST_WDATA;
                ST_WDATA: state_d = ST_WPAR;
                ST_RDATA: state_d = ST_RPAR;
                ST_RPAR:  state_d = ST_RTRN;
                default:  state_d = ST_DONE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Frame sequencing and capture registers, advanced on the SWCLK sampling edge.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESET_ST;
            cnt_q         <= '0;
            req_q         <= 7'd0;
            rnw_q         <= 1'b0;
            req_err_q     <= 1'b0;
            ack_q         <= 3'd0;
            ack_ok_q      <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            wpar_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q != ST_DONE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_d == ST_DONE) begin
                frame_done_q <= 1'b1;
            end
            case (state_q)
                ST_REQ: begin
                    req_q <= req_full_s[7:1];
                    if (last_s) begin
                        rnw_q     <= req_full_s[2];
                        req_err_q <= req_bad(req_full_s);
                    end
                end
                ST_ACK: begin
                    ack_q <= ack_full_s;
                    if (last_s) begin
                        ack_ok_q <= ack_ok_s;
                    end
                end
                ST_WDATA: wpar_q  <= wpar_q ^ mosi;
                ST_RDATA: rdata_q <= {swdio, rdata_q[DATA_W-1:1]};
                ST_RPAR: begin
                    rdata_valid_q <= 1'b1;
                    parity_err_q  <= odd_par_err(rdata_q, swdio);
                end
                default: ;
            endcase
        end
    end

    // Drive enable and clock gate change on the falling edge so they switch while SCK is low.
    always_ff @(negedge sck or negedge rst_n) begin
        if (!rst_n) begin
            oe_q     <= host_drives(RESET_ST);
            clk_en_q <= clk_enabled(RESET_ST);
        end else begin
            oe_q     <= host_drives(state_q);
            clk_en_q <= clk_enabled(state_q);
        end
    end

    assign drv_s    = ((WR_PAR_GEN != 0) && (state_q == ST_WPAR)) ? ~wpar_q : mosi;
    assign mirror_s = (state_q == ST_ACK) || (state_q == ST_RDATA) || (state_q == ST_RPAR);

    // rst_n gating makes an abort release the line and stop SWCLK without waiting for an edge.
    assign swdio_oe    = oe_q & rst_n;
    assign swclk       = sck & clk_en_q & rst_n;
    assign swdio       = swdio_oe ? drv_s : 1'bz;
    assign miso        = mirror_s ? swdio : 1'b0;
    assign ack         = ack_q;
    assign ack_ok      = ack_ok_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign parity_err  = parity_err_q;
    assign req_err     = req_err_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_swd_spi_bridge_v2.sv
// Randomized bench for swd_spi_bridge_v2: a default instance and a short-frame instance
// are checked bit by bit against a per-frame wire schedule built from the packet rules.
module tb_swd_spi_bridge_v2;

    localparam byte R_PAD  = 8'd0;
    localparam byte R_HOST = 8'd1;
    localparam byte R_TGT  = 8'd2;
    localparam byte R_IDLE = 8'd3;
    localparam byte R_DONE = 8'd4;

    logic        sck;
    logic        rst_a_n, rst_b_n;
    logic        mosi, tgt_oe, tgt_val, sel;
    wire         swdio_a, swdio_b;

    logic        miso_a, swclk_a, oe_a, ack_ok_a, rdata_valid_a, parity_err_a, req_err_a, frame_done_a;
    logic [2:0]  ack_a;
    logic [31:0] rdata_a;
    logic        miso_b, swclk_b, oe_b, ack_ok_b, rdata_valid_b, parity_err_b, req_err_b, frame_done_b;
    logic [2:0]  ack_b;
    logic [7:0]  rdata_b;

    logic        o_miso, o_swclk, o_oe, o_swdio, o_ack_ok, o_rdata_valid, o_parity_err, o_req_err, o_frame_done;
    logic [2:0]  o_ack;
    logic [31:0] o_rdata;

    int n_checks;
    int n_errors;

    byte role_q[$];
    bit  hb_q[$];
    bit  tg_q[$];
    bit  drv_q[$];

    assign swdio_a = (tgt_oe && !sel) ? tgt_val : 1'bz;
    assign swdio_b = (tgt_oe && sel) ? tgt_val : 1'bz;

    swd_spi_bridge_v2 u_dut_a (
        .sck(sck), .rst_n(rst_a_n), .mosi(mosi), .miso(miso_a), .swclk(swclk_a),
        .swdio(swdio_a), .swdio_oe(oe_a), .ack(ack_a), .ack_ok(ack_ok_a), .rdata(rdata_a),
        .rdata_valid(rdata_valid_a), .parity_err(parity_err_a), .req_err(req_err_a),
        .frame_done(frame_done_a)
    );

    swd_spi_bridge_v2 #(
        .PAD_BITS(0), .TRN_CYCLES(2), .WR_TRN(0), .DATA_W(8), .WR_PAR_GEN(1)
    ) u_dut_b (
        .sck(sck), .rst_n(rst_b_n), .mosi(mosi), .miso(miso_b), .swclk(swclk_b),
        .swdio(swdio_b), .swdio_oe(oe_b), .ack(ack_b), .ack_ok(ack_ok_b), .rdata(rdata_b),
        .rdata_valid(rdata_valid_b), .parity_err(parity_err_b), .req_err(req_err_b),
        .frame_done(frame_done_b)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    always_comb begin
        if (sel) begin
            o_miso = miso_b; o_swclk = swclk_b; o_oe = oe_b; o_swdio = swdio_b;
            o_ack = ack_b; o_ack_ok = ack_ok_b; o_rdata = {24'd0, rdata_b};
            o_rdata_valid = rdata_valid_b; o_parity_err = parity_err_b;
            o_req_err = req_err_b; o_frame_done = frame_done_b;
        end else begin
            o_miso = miso_a; o_swclk = swclk_a; o_oe = oe_a; o_swdio = swdio_a;
            o_ack = ack_a; o_ack_ok = ack_ok_a; o_rdata = rdata_a;
            o_rdata_valid = rdata_valid_a; o_parity_err = parity_err_a;
            o_req_err = req_err_a; o_frame_done = frame_done_a;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit rbit();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    task automatic push(input byte r, input bit h, input bit t, input bit d);
        role_q.push_back(r);
        hb_q.push_back(h);
        tg_q.push_back(t);
        drv_q.push_back(d);
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst_b_n = v;
        else     rst_a_n = v;
    endtask

    task automatic check_status(input string name, input logic [2:0] a, input bit ok,
                                input logic [31:0] rd, input bit rv, input bit pe, input bit re);
        check_eq({name, " ack"}, 32'(o_ack), 32'(a));
        check_eq({name, " ack_ok"}, 32'(o_ack_ok), 32'(ok));
        check_eq({name, " rdata"}, o_rdata, rd);
        check_eq({name, " rdata_valid"}, 32'(o_rdata_valid), 32'(rv));
        check_eq({name, " parity_err"}, 32'(o_parity_err), 32'(pe));
        check_eq({name, " req_err"}, 32'(o_req_err), 32'(re));
    endtask

    // One SWD packet: s selects the instance, flip corrupts the data parity bit on the wire,
    // abort_at >= 0 pulls rst_n low in the high half of that bit.
    task automatic run_frame(input bit s, input logic [7:0] req, input logic [2:0] ackv,
                             input logic [31:0] data_in, input bit flip, input int abort_at,
                             input string name);
        int pad, trn, dw, len;
        bit gen, rnw, ok, opar, rerr;
        byte r;
        logic [31:0] data;
        sel  = s;
        pad  = s ? 0 : 3;
        trn  = s ? 2 : 1;
        dw   = s ? 8 : 32;
        gen  = s;
        data = (dw == 32) ? data_in : (data_in & ((32'd1 << dw) - 32'd1));
        opar = ($countones(data) % 2) == 0;
        rnw  = req[2];
        ok   = (ackv == 3'b001);
        rerr = !req[0] || req[6] || !req[7] || (req[5] != (($countones(req[4:1]) % 2) == 1));

        role_q.delete(); hb_q.delete(); tg_q.delete(); drv_q.delete();
        for (int i = 0; i < pad; i++) push(R_PAD, rbit(), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push(R_HOST, req[i], 1'b0, req[i]);
        for (int i = 0; i < trn; i++) push(R_IDLE, rbit(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(R_TGT, rbit(), ackv[i], 1'b0);
        if (ok && !rnw) begin
            for (int i = 0; i < dw; i++) push(R_HOST, data[i], 1'b0, data[i]);
            push(R_HOST, opar ^ flip, 1'b0, gen ? opar : (opar ^ flip));
        end else if (ok) begin
            for (int i = 0; i < dw; i++) push(R_TGT, rbit(), data[i], 1'b0);
            push(R_TGT, rbit(), opar ^ flip, 1'b0);
            for (int i = 0; i < trn; i++) push(R_IDLE, rbit(), 1'b0, 1'b0);
        end else begin
            for (int i = 0; i < trn; i++) push(R_IDLE, rbit(), 1'b0, 1'b0);
        end
        len = role_q.size();

        for (int k = 0; k < len + 2; k++) begin
            @(negedge sck); #1;
            if (k == 0) set_rst(1'b1);
            if (k < len) begin
                r = role_q[k];
                mosi = hb_q[k]; tgt_oe = (r == R_TGT); tgt_val = tg_q[k];
            end else begin
                r = R_DONE;
                mosi = rbit(); tgt_oe = 1'b0; tgt_val = 1'b0;
            end
            #1;
            check_eq($sformatf("%s oe[%0d]", name, k), 32'(o_oe), 32'(r == R_HOST));
            if (r == R_HOST)
                check_eq($sformatf("%s swdio[%0d]", name, k), 32'(o_swdio), 32'(drv_q[k]));
            check_eq($sformatf("%s miso[%0d]", name, k), 32'(o_miso),
                     32'((r == R_TGT) ? tg_q[k] : 1'b0));
            check_eq($sformatf("%s done[%0d]", name, k), 32'(o_frame_done), 32'(k >= len));
            @(posedge sck); #2;
            check_eq($sformatf("%s swclk[%0d]", name, k), 32'(o_swclk),
                     32'((r != R_PAD) && (r != R_DONE)));
            if (k == abort_at) begin
                set_rst(1'b0);
                tgt_oe = 1'b0;
                #1;
                check_eq({name, " abort oe"}, 32'(o_oe), 32'd0);
                check_eq({name, " abort swclk"}, 32'(o_swclk), 32'd0);
                check_eq({name, " abort done"}, 32'(o_frame_done), 32'd0);
                check_eq({name, " abort ack"}, 32'(o_ack), 32'd0);
                return;
            end
        end
        check_status(name, ackv, ok, (ok && rnw) ? data : 32'd0, ok && rnw,
                     ok && rnw && flip, rerr);
        @(negedge sck); #1;
        set_rst(1'b0);
        tgt_oe = 1'b0;
    endtask

    function automatic logic [7:0] rand_req();
        logic [3:0] f;
        logic [7:0] r;
        f = 4'($urandom);
        r = {1'b1, 1'b0, ^f, f, 1'b1};
        if ($urandom_range(7) == 0) r = r ^ (8'd1 << $urandom_range(7));
        return r;
    endfunction

    initial begin
        logic [2:0] ack_tbl [5];
        ack_tbl = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b111};
        n_checks = 0; n_errors = 0;
        sel = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0;
        mosi = 1'b0; tgt_oe = 1'b0; tgt_val = 1'b0;

        repeat (2) @(negedge sck);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            @(posedge sck); #2;
            check_eq("reset swclk", 32'(o_swclk), 32'd0);
            check_eq("reset oe", 32'(o_oe), 32'd0);
            check_eq("reset miso", 32'(o_miso), 32'd0);
            check_eq("reset done", 32'(o_frame_done), 32'd0);
            check_status("reset", 3'b000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        end

        run_frame(1'b0, 8'h81, 3'b001, 32'hA55A3C5C, 1'b0, -1, "wr_ok");
        run_frame(1'b0, 8'h81, 3'b010, 32'hA55A3C5C, 1'b0, -1, "wr_wait");
        run_frame(1'b0, 8'hA5, 3'b001, 32'h2BA01477, 1'b0, -1, "rd_ok");
        run_frame(1'b0, 8'hA5, 3'b001, 32'h2BA01477, 1'b1, -1, "rd_badpar");
        run_frame(1'b0, 8'hA5, 3'b100, 32'h2BA01477, 1'b0, -1, "rd_fault");
        run_frame(1'b0, 8'h81, 3'b001, 32'hA55A3C5C, 1'b0, 20, "wr_abort");
        run_frame(1'b0, 8'h81, 3'b001, 32'h12345678, 1'b0, -1, "wr_after_abort");
        run_frame(1'b1, 8'h81, 3'b001, 32'h0000005A, 1'b1, -1, "p_wr_gen");
        run_frame(1'b1, 8'h80, 3'b001, 32'h000000C3, 1'b0, -1, "p_badreq");
        run_frame(1'b1, 8'hA5, 3'b001, 32'h00000096, 1'b0, -1, "p_rd_ok");

        for (int i = 0; i < 16; i++)
            run_frame(1'b0, rand_req(), ack_tbl[$urandom_range(4)], $urandom,
                      ($urandom_range(3) == 0), -1, $sformatf("rnd_a%0d", i));
        for (int i = 0; i < 12; i++)
            run_frame(1'b1, rand_req(), ack_tbl[$urandom_range(4)], $urandom,
                      ($urandom_range(3) == 0), -1, $sformatf("rnd_b%0d", i));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
